// File: rtl/pc_unit_pkg.sv
// rv_pc_pkg: shared encodings and default vectors for the program-counter unit.
package rv_pc_pkg;
   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
   // Ordered by priority so a plain >= compares redirect precedence.
   typedef enum logic [1:0] {NONE = 2'd0, BRANCH = 2'd1, JUMP = 2'd2, TRAP = 2'd3} kind_t;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
   localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0040_0180;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: redirect/control inputs and PC status outputs of the program-counter unit.
interface pc_unit_if #(parameter int N = 32, parameter int CNT_W = 32);
   logic enable, branch_taken, jump, trap, halt_req, resume;
   logic [N-1:0] branch_target, jump_target;
   logic [N-1:0] pc_value, pc_plus_inc, pc_prev, epc_value;
   logic fetch_valid, misaligned, halted;
   logic [CNT_W-1:0] fetch_count;
   modport master (
      output enable, branch_taken, branch_target, jump, jump_target, trap, halt_req, resume,
      input  pc_value, pc_plus_inc, pc_prev, epc_value, fetch_valid, misaligned, halted, fetch_count
   );
   modport slave (
      input  enable, branch_taken, branch_target, jump, jump_target, trap, halt_req, resume,
      output pc_value, pc_plus_inc, pc_prev, epc_value, fetch_valid, misaligned, halted, fetch_count
   );
endinterface

// File: rtl/pc_unit_next_sel.sv
// pc_next_sel: priority mux of trap/jump/branch/pending/sequential with alignment check.
module pc_next_sel
   import rv_pc_pkg::*;
#(
   parameter int N = 32,
   parameter logic [N-1:0] TRAP_VECTOR = N'(TRAP_VECTOR_DEF),
   parameter int INC = 4
) (
   input  logic [N-1:0] pc,
   input  logic         trap,
   input  logic         jump,
   input  logic [N-1:0] jump_target,
   input  logic         branch_taken,
   input  logic [N-1:0] branch_target,
   input  kind_t        pend_kind,
   input  logic [N-1:0] pend_target,
   output kind_t        live_kind,
   output logic [N-1:0] live_target,
   output kind_t        kind,
   output logic [N-1:0] target,
   output logic         misaligned,
   output logic [N-1:0] next_pc
);
   // For traps the target carries the faulting PC so it can go straight to epc.
   always_comb begin
      live_kind   = trap ? TRAP : jump ? JUMP : branch_taken ? BRANCH : NONE;
      live_target = trap ? pc : jump ? jump_target : branch_taken ? branch_target : pc;
      kind        = live_kind != NONE ? live_kind : pend_kind;
      target      = live_kind != NONE ? live_target : pend_target;
      misaligned  = (kind == JUMP || kind == BRANCH) && |(target & N'(INC - 1));
      next_pc     = (kind == TRAP || misaligned) ? TRAP_VECTOR : kind == NONE ? pc + N'(INC) : target;
   end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with boot cycle, halt/resume FSM, stall-safe redirect buffer,
// misaligned-target trapping and a fetch counter.
module pc_unit
   import rv_pc_pkg::*;
#(
   parameter int N = 32,
   parameter logic [N-1:0] RESET_VECTOR = N'(RESET_VECTOR_DEF),
   parameter logic [N-1:0] TRAP_VECTOR = N'(TRAP_VECTOR_DEF),
   parameter int INC = 4,
   parameter int CNT_W = 32
) (
   input logic clk,
   input logic reset,
   pc_unit_if.slave bus
);
   state_t state, state_d;
   kind_t pend_kind, live_kind, kind;
   logic [N-1:0] pc, prev, epc, pend_target, live_target, target, next_pc;
   logic [CNT_W-1:0] cnt;
   logic mis, mis_q, adv, cap;
   pc_next_sel #(.N(N), .TRAP_VECTOR(TRAP_VECTOR), .INC(INC)) u_sel (
      .pc(pc), .trap(bus.trap), .jump(bus.jump), .jump_target(bus.jump_target),
      .branch_taken(bus.branch_taken), .branch_target(bus.branch_target),
      .pend_kind(pend_kind), .pend_target(pend_target), .live_kind(live_kind),
      .live_target(live_target), .kind(kind), .target(target), .misaligned(mis),
      .next_pc(next_pc)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= BOOT;
      else state <= state_d;
   always_comb begin
      state_d = state == HALT ? (bus.resume ? RUN : HALT)
              : (state == RUN && bus.halt_req && bus.enable) ? HALT : RUN;
      adv     = state == RUN && bus.enable && !bus.halt_req;
      cap     = state == RUN && !bus.enable && live_kind != NONE && live_kind >= pend_kind;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= RESET_VECTOR;
         prev <= RESET_VECTOR;
         epc <= '0;
         cnt <= '0;
         mis_q <= 1'b0;
         pend_kind <= NONE;
         pend_target <= '0;
      end else begin
         mis_q <= adv && mis;
         if (adv) begin
            pc <= next_pc;
            prev <= pc;
            cnt <= cnt + CNT_W'(1);
            if (kind == TRAP || mis) epc <= target;
         end
         // Any enabled RUN cycle either consumes the entry or enters HALT; both drop it.
         if (state == RUN && bus.enable) pend_kind <= NONE;
         else if (cap) begin
            pend_kind <= live_kind;
            pend_target <= live_target;
         end
      end
   end
   assign bus.pc_value    = pc;
   assign bus.pc_plus_inc = pc + N'(INC);
   assign bus.pc_prev     = prev;
   assign bus.epc_value   = epc;
   assign bus.fetch_valid = state == RUN;
   assign bus.misaligned  = mis_q;
   assign bus.halted      = state == HALT;
   assign bus.fetch_count = cnt;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit against a behavioural model.
module tb_pc_unit;
   localparam logic [31:0] RV = 32'h0040_0000;
   localparam logic [31:0] TV = 32'h0040_0180;
   logic clk = 1'b0, reset = 1'b0;
   logic en, br, jp, tr, hr, rs;
   logic [31:0] bt, jt;
   int n_checks = 0, n_fail = 0;
   always #5 clk = ~clk;
   pc_unit_if #(.N(32), .CNT_W(32)) bus ();
   assign bus.enable = en;
   assign bus.branch_taken = br;
   assign bus.branch_target = bt;
   assign bus.jump = jp;
   assign bus.jump_target = jt;
   assign bus.trap = tr;
   assign bus.halt_req = hr;
   assign bus.resume = rs;
   pc_unit #(.N(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INC(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );
   // Behavioural model: booting/halted flags, one pending request with numeric priority.
   bit m_boot, m_halt, m_mis, m_pv;
   int m_pp;
   bit [31:0] m_pc, m_prev, m_epc, m_cnt, m_pt;
   task automatic model_reset();
      m_boot = 1; m_halt = 0; m_mis = 0; m_pv = 0; m_pp = 0;
      m_pc = RV; m_prev = RV; m_epc = 0; m_cnt = 0; m_pt = 0;
   endtask
   task automatic model_next();
      bit [31:0] t;
      bit redir;
      int p;
      m_mis = 0;
      if (m_boot) m_boot = 0;
      else if (m_halt) begin
         if (rs) m_halt = 0;
      end else if (en && hr) begin
         m_halt = 1; m_pv = 0;
      end else if (en) begin
         m_prev = m_pc;
         m_cnt++;
         if (tr || (!jp && !br && m_pv && m_pp == 3)) begin
            m_epc = m_pc; m_pc = TV;
         end else begin
            redir = jp || br || m_pv;
            t = jp ? jt : br ? bt : m_pv ? m_pt : m_pc + 4;
            if (redir && t % 4 != 0) begin
               m_epc = t; m_pc = TV; m_mis = 1;
            end else m_pc = t;
         end
         m_pv = 0;
      end else begin
         p = tr ? 3 : jp ? 2 : br ? 1 : 0;
         if (p > 0 && (!m_pv || p >= m_pp)) begin
            m_pv = 1; m_pp = p; m_pt = jp ? jt : bt;
         end
      end
   endtask
   task automatic idle();
      en = 1; br = 0; jp = 0; tr = 0; hr = 0; rs = 0; bt = 0; jt = 0;
   endtask
   task automatic tick();
      model_next();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic test_reset();
      idle();
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1;
      n_checks += 6;
      if (bus.pc_value !== RV) begin n_fail++; $display("FAIL boot_pc got %h want %h", bus.pc_value, RV); end
      if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b want 0", bus.fetch_valid); end
      if (bus.fetch_count !== 0) begin n_fail++; $display("FAIL boot_count got %0d want 0", bus.fetch_count); end
      if (bus.epc_value !== 0) begin n_fail++; $display("FAIL boot_epc got %h want 0", bus.epc_value); end
      if (bus.pc_prev !== RV) begin n_fail++; $display("FAIL boot_prev got %h want %h", bus.pc_prev, RV); end
      if (bus.halted !== 1'b0 || bus.misaligned !== 1'b0) begin n_fail++; $display("FAIL boot_flags got %b%b want 00", bus.halted, bus.misaligned); end
      tick();
      n_checks += 2;
      if (bus.pc_value !== RV) begin n_fail++; $display("FAIL run_hold got %h want %h", bus.pc_value, RV); end
      if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL run_valid got %b want 1", bus.fetch_valid); end
      tick();
      n_checks++;
      if (bus.pc_value !== 32'h400004) begin n_fail++; $display("FAIL seq1 got %h want 400004", bus.pc_value); end
      tick();
      n_checks += 3;
      if (bus.pc_value !== 32'h400008) begin n_fail++; $display("FAIL seq2 got %h want 400008", bus.pc_value); end
      if (bus.fetch_count !== 2) begin n_fail++; $display("FAIL seq_count got %0d want 2", bus.fetch_count); end
      if (bus.pc_plus_inc !== 32'h40000c) begin n_fail++; $display("FAIL plus_inc got %h want 40000c", bus.pc_plus_inc); end
   endtask
   task automatic test_jump_priority();
      logic [31:0] old;
      old = bus.pc_value;
      jp = 1; jt = 32'h400100; br = 1; bt = 32'h400200;
      tick();
      idle();
      n_checks += 2;
      if (bus.pc_value !== 32'h400100) begin n_fail++; $display("FAIL jump_pc got %h want 400100", bus.pc_value); end
      if (bus.pc_prev !== old) begin n_fail++; $display("FAIL jump_prev got %h want %h", bus.pc_prev, old); end
   endtask
   task automatic test_misaligned();
      br = 1; bt = 32'h400102;
      tick();
      idle();
      n_checks += 3;
      if (bus.pc_value !== TV) begin n_fail++; $display("FAIL mis_pc got %h want %h", bus.pc_value, TV); end
      if (bus.epc_value !== 32'h400102) begin n_fail++; $display("FAIL mis_epc got %h want 400102", bus.epc_value); end
      if (bus.misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got %b want 1", bus.misaligned); end
      tick();
      n_checks += 2;
      if (bus.misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_clear got %b want 0", bus.misaligned); end
      if (bus.pc_value !== TV + 4) begin n_fail++; $display("FAIL mis_next got %h want %h", bus.pc_value, TV + 4); end
   endtask
   task automatic test_stall();
      logic [31:0] held;
      held = bus.pc_value;
      for (int i = 0; i < 3; i++) begin
         en = 0; br = (i == 1); bt = 32'h400040;
         tick();
         n_checks++;
         if (bus.pc_value !== held) begin n_fail++; $display("FAIL stall_hold%0d got %h want %h", i, bus.pc_value, held); end
      end
      idle();
      tick();
      n_checks++;
      if (bus.pc_value !== 32'h400040) begin n_fail++; $display("FAIL stall_redirect got %h want 400040", bus.pc_value); end
   endtask
   task automatic test_stall_priority();
      logic [31:0] held;
      idle(); en = 0; jp = 1; jt = 32'h400200;
      tick();
      jp = 0; br = 1; bt = 32'h400300;
      tick();
      idle();
      tick();
      n_checks++;
      if (bus.pc_value !== 32'h400200) begin n_fail++; $display("FAIL pend_keep got %h want 400200", bus.pc_value); end
      en = 0; br = 1; bt = 32'h400040;
      tick();
      idle(); jp = 1; jt = 32'h400500;
      tick();
      idle();
      n_checks++;
      if (bus.pc_value !== 32'h400500) begin n_fail++; $display("FAIL live_wins got %h want 400500", bus.pc_value); end
      tick();
      n_checks++;
      if (bus.pc_value !== 32'h400504) begin n_fail++; $display("FAIL pend_dropped got %h want 400504", bus.pc_value); end
      held = bus.pc_value;
      en = 0; tr = 1;
      tick();
      idle();
      tick();
      n_checks += 2;
      if (bus.pc_value !== TV) begin n_fail++; $display("FAIL pend_trap got %h want %h", bus.pc_value, TV); end
      if (bus.epc_value !== held) begin n_fail++; $display("FAIL pend_trap_epc got %h want %h", bus.epc_value, held); end
   endtask
   task automatic test_halt();
      logic [31:0] frozen, fcnt;
      frozen = bus.pc_value; fcnt = bus.fetch_count;
      hr = 1;
      tick();
      hr = 0;
      for (int i = 0; i < 5; i++) begin
         n_checks += 3;
         if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag%0d got %b want 1", i, bus.halted); end
         if (bus.pc_value !== frozen) begin n_fail++; $display("FAIL halt_pc%0d got %h want %h", i, bus.pc_value, frozen); end
         if (bus.fetch_count !== fcnt || bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL halt_cnt%0d got %0d/%b want %0d/0", i, bus.fetch_count, bus.fetch_valid, fcnt); end
         jp = 1; jt = 32'h400800; tr = (i == 2); hr = (i == 4); rs = (i == 4);
         tick();
      end
      idle();
      n_checks += 2;
      if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL resume_flag got %b want 0", bus.halted); end
      if (bus.pc_value !== frozen) begin n_fail++; $display("FAIL resume_pc got %h want %h", bus.pc_value, frozen); end
      tick();
      n_checks++;
      if (bus.pc_value !== frozen + 4) begin n_fail++; $display("FAIL resume_adv got %h want %h", bus.pc_value, frozen + 4); end
   endtask
   task automatic test_wrap();
      jp = 1; jt = 32'hffff_fffc;
      tick();
      idle();
      n_checks += 2;
      if (bus.pc_value !== 32'hffff_fffc) begin n_fail++; $display("FAIL wrap_jump got %h want fffffffc", bus.pc_value); end
      if (bus.pc_plus_inc !== 32'h0) begin n_fail++; $display("FAIL wrap_inc got %h want 0", bus.pc_plus_inc); end
      tick();
      n_checks++;
      if (bus.pc_value !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h want 0", bus.pc_value); end
      jp = 1; jt = RV;
      tick();
      idle();
   endtask
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 3) != 0);
         tr = ($urandom_range(0, 15) == 0);
         jp = ($urandom_range(0, 5) == 0);
         br = ($urandom_range(0, 3) == 0);
         hr = ($urandom_range(0, 19) == 0);
         rs = ($urandom_range(0, 3) == 0);
         jt = RV + {22'd0, 8'($urandom_range(0, 255)), 2'b00} + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
         bt = RV + {22'd0, 8'($urandom_range(0, 255)), 2'b00} + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
         tick();
         n_checks += 4;
         if (bus.pc_value !== m_pc || bus.pc_plus_inc !== m_pc + 4) begin n_fail++; $display("FAIL rnd_pc%0d got %h/%h want %h", i, bus.pc_value, bus.pc_plus_inc, m_pc); end
         if (bus.pc_prev !== m_prev || bus.epc_value !== m_epc) begin n_fail++; $display("FAIL rnd_prev_epc%0d got %h/%h want %h/%h", i, bus.pc_prev, bus.epc_value, m_prev, m_epc); end
         if (bus.fetch_count !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt%0d got %0d want %0d", i, bus.fetch_count, m_cnt); end
         if (bus.halted !== m_halt || bus.misaligned !== m_mis || bus.fetch_valid !== (!m_halt && !m_boot)) begin
            n_fail++; $display("FAIL rnd_flags%0d got h%b m%b v%b want h%b m%b v%b", i, bus.halted, bus.misaligned, bus.fetch_valid, m_halt, m_mis, !m_halt && !m_boot);
         end
      end
      idle();
      rs = 1;
      tick();
      idle();
   endtask
   task automatic test_reset_mid_halt();
      en = 0; br = 1; bt = 32'h400900;
      tick();
      idle(); hr = 1;
      tick();
      hr = 0;
      tick();
      n_checks++;
      if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL pre_reset_halt got %b want 1", bus.halted); end
      #2 reset = 0;
      model_reset();
      #1;
      n_checks += 3;
      if (bus.pc_value !== RV) begin n_fail++; $display("FAIL async_pc got %h want %h", bus.pc_value, RV); end
      if (bus.halted !== 1'b0 || bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL async_state got h%b v%b want h0 v0", bus.halted, bus.fetch_valid); end
      if (bus.fetch_count !== 0 || bus.epc_value !== 0) begin n_fail++; $display("FAIL async_regs got %0d/%h want 0/0", bus.fetch_count, bus.epc_value); end
      @(negedge clk);
      reset = 1;
      tick();
      tick();
      n_checks++;
      if (bus.pc_value !== 32'h400004) begin n_fail++; $display("FAIL post_reset got %h want 400004 (pending must be gone)", bus.pc_value); end
   endtask
   initial begin
      test_reset();
      test_jump_priority();
      test_misaligned();
      test_stall();
      test_stall_priority();
      test_halt();
      test_wrap();
      test_random();
      test_reset_mid_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
